// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_pkg
//  Description : Shared types and constants for the I2S receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

   // Word-alignment states of the receiver.
   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ALIGN   = 2'd1,
      RECEIVE = 2'd2
   } state_t;

   // Flops in each pin synchroniser chain.
   localparam int SYNC_STAGES = 2;

   // Word-select level for each channel.
   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2s_receive_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_receive_if
//  Description : I2S serial pins plus the parallel frame output of the
//                receiver. The master drives the serial pins, the slave
//                (receiver) drives the frame outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2s_receive_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  sck;
   logic                  ws;
   logic                  sd;
   logic [DATA_WIDTH-1:0] data_left;
   logic [DATA_WIDTH-1:0] data_right;
   logic                  valid;
   logic                  locked;

   modport master (
      output sck, ws, sd,
      input  data_left, data_right, valid, locked
   );

   modport slave (
      input  sck, ws, sd,
      output data_left, data_right, valid, locked
   );
endinterface
`default_nettype wire

// File: rtl/i2s_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx_sync
//  Description : Multi-flop synchroniser for one asynchronous pin, followed
//                by a history flop. The level output and the registered
//                rise pulse are time-aligned so that several instances can
//                be sampled together on the rise of another pin.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx_sync
   import i2s_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise
);

   logic [STAGES-1:0] chain;
   logic              prev;

   // Metastability chain: the pin enters at bit 0, the settled value leaves at the top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], din};
      end
   end

   // One cycle of history gives the rising-edge pulse, registered to stay aligned with level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev <= 1'b0;
         rise <= 1'b0;
      end else begin
         prev <= chain[STAGES-1];
         rise <= chain[STAGES-1] & ~prev;
      end
   end

   assign level = prev;

endmodule
`default_nettype wire

// File: rtl/i2s_receive.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_receive
//  Description : I2S receiver. Oversamples sck/ws/sd in the clk domain,
//                acquires word alignment from ws transitions and presents
//                left-justified left/right words with a one-cycle valid
//                strobe per complete left+right frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_receive
   import i2s_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   i2s_receive_if.slave    bus
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   state_t                state;
   state_t                state_nx;

   logic                  sck_rise;
   logic                  sck_level;
   logic                  ws_s;
   logic                  sd_s;
   logic                  ws_rise;
   logic                  sd_rise;
   logic                  unused_sync;

   logic                  primed;
   logic                  ws_d1;
   logic                  ws_d2;
   logic                  word_start;
   logic                  word_end;

   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] shreg_nx;
   logic [DATA_WIDTH-1:0] msb_bit;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cnt_base;
   logic [CNT_W-1:0]      cnt_nx;
   logic                  left_seen;

   logic [DATA_WIDTH-1:0] left_word;
   logic [DATA_WIDTH-1:0] right_word;
   logic                  frame_valid;
   logic                  lock_flag;

   i2s_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (bus.sck),
      .level (sck_level),
      .rise  (sck_rise)
   );

   i2s_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_ws (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (bus.ws),
      .level (ws_s),
      .rise  (ws_rise)
   );

   i2s_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_sd (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (bus.sd),
      .level (sd_s),
      .rise  (sd_rise)
   );

   // Only the sck edge and the ws/sd levels are needed.
   assign unused_sync = &{1'b0, sck_level, ws_rise, sd_rise};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SEARCH;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and word boundary decode. The very first sck rise after
   // reset only primes ws_d1, so the reset value of ws cannot fake a transition.
   always_comb begin
      state_nx   = state;
      word_start = 1'b0;
      word_end   = sck_rise && (state != SEARCH) && (ws_s != ws_d1);
      case (state)
         SEARCH: begin
            if (sck_rise && primed && (ws_s != ws_d1)) begin
               state_nx = ALIGN;
            end
         end
         ALIGN: begin
            if (sck_rise) begin
               state_nx   = RECEIVE;
               word_start = 1'b1;
            end
         end
         RECEIVE: begin
            if (sck_rise && (ws_d1 != ws_d2)) begin
               word_start = 1'b1;
            end
         end
         default: begin
            state_nx = SEARCH;
         end
      endcase
   end

   // Shift-register update for the bit on this sck rise: a word start
   // restarts from an empty word, bits past DATA_WIDTH are dropped.
   always_comb begin
      shreg_nx = word_start ? '0 : shreg;
      cnt_base = word_start ? '0 : cnt;
      cnt_nx   = cnt_base;
      msb_bit  = {sd_s, {(DATA_WIDTH-1){1'b0}}};
      if (cnt_base < CNT_W'(DATA_WIDTH)) begin
         shreg_nx = shreg_nx | (msb_bit >> cnt_base);
         cnt_nx   = cnt_base + 1'b1;
      end
   end

   // Bit capture, ws history, word commit and frame strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         primed      <= 1'b0;
         ws_d1       <= 1'b0;
         ws_d2       <= 1'b0;
         shreg       <= '0;
         cnt         <= '0;
         left_seen   <= 1'b0;
         left_word   <= '0;
         right_word  <= '0;
         frame_valid <= 1'b0;
         lock_flag   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         if (sck_rise) begin
            primed <= 1'b1;
            ws_d1  <= ws_s;
            ws_d2  <= ws_d1;
            if (state != SEARCH) begin
               shreg <= shreg_nx;
               cnt   <= cnt_nx;
            end
            if (state == ALIGN) begin
               lock_flag <= 1'b1;
            end
            if (word_end) begin
               if (ws_d1 == CH_LEFT) begin
                  left_word <= shreg_nx;
                  left_seen <= 1'b1;
               end else if (ws_d1 == CH_RIGHT) begin
                  right_word <= shreg_nx;
                  if (left_seen) begin
                     frame_valid <= 1'b1;
                     left_seen   <= 1'b0;
                  end
               end
            end
         end
      end
   end

   assign bus.data_left  = left_word;
   assign bus.data_right = right_word;
   assign bus.valid      = frame_valid;
   assign bus.locked     = lock_flag;

endmodule
`default_nettype wire
